uart_rx_os16: RTL and testbench



---
 rtl/uart_rx_os16.sv | 150 +++++++++++++++
 tb/tb_uart_rx_os16.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// UART receiver sampling on a 16x oversample tick: mid-bit start validation,
// LSB-first data, optional parity, stop check, valid/ready output with overrun.
module uart_rx_os16 #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 oversample_tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t               state_reg;
    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    logic [3:0]           tick_cnt_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bad_reg;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg;
    logic                 frame_err_reg;
    logic                 parity_err_reg;
    logic                 overrun_reg;
    logic                 mid_sample;
    logic                 can_load;

    assign mid_sample = oversample_tick && (tick_cnt_reg == 4'd15);
    assign can_load   = !rx_valid_reg || rx_ready;

    // Line idles high, so both synchronizer flops reset to 1 to avoid a false start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_bad_reg <= 1'b0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg    <= START;
                        tick_cnt_reg <= '0;
                    end
                end
                START: begin
                    if (oversample_tick) begin
                        if (tick_cnt_reg == 4'd7) begin
                            if (!rx_s_reg) begin
                                state_reg      <= DATA;
                                tick_cnt_reg   <= '0;
                                bit_cnt_reg    <= '0;
                                parity_bad_reg <= 1'b0;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 4'd1;
                        end
                    end
                end
                DATA: begin
                    // tick_cnt wraps 15 -> 0, so each later sample is a full bit after the last.
                    if (oversample_tick) begin
                        tick_cnt_reg <= tick_cnt_reg + 4'd1;
                    end
                    if (mid_sample) begin
                        shift_reg   <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_reg <= PARITY_EN ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (oversample_tick) begin
                        tick_cnt_reg <= tick_cnt_reg + 4'd1;
                    end
                    if (mid_sample) begin
                        parity_bad_reg <= ((^shift_reg) ^ rx_s_reg) != PARITY_ODD;
                        state_reg      <= STOP;
                    end
                end
                STOP: begin
                    if (oversample_tick) begin
                        tick_cnt_reg <= tick_cnt_reg + 4'd1;
                    end
                    if (mid_sample) begin
                        if (can_load) begin
                            rx_data_reg    <= shift_reg;
                            frame_err_reg  <= !rx_s_reg;
                            parity_err_reg <= parity_bad_reg;
                            rx_valid_reg   <= 1'b1;
                        end else begin
                            overrun_reg <= 1'b1;
                        end
                        state_reg <= rx_s_reg ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: a no-parity and an odd-parity instance, tick every 4 clk,
// directed corner sequences, a parity vector table and randomized frames vs a model.
module tb_uart_rx_os16;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] tc = 2'd0;
    logic       oversample_tick;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       man_ready_a = 1'b0;
    logic       rand_ready = 1'b0;
    logic       rand_mode = 1'b0;
    logic       rx_ready_a;
    logic       ready_b = 1'b0;

    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, frame_err_a, parity_err_a, overrun_a, busy_a;
    logic       rx_valid_b, frame_err_b, parity_err_b, overrun_b, busy_b;

    assign oversample_tick = (tc == 2'd3);
    assign rx_ready_a      = rand_mode ? rand_ready : man_ready_a;

    always #5 clk = ~clk;
    always @(posedge clk) tc <= tc + 2'd1;
    always @(posedge clk) rand_ready <= 1'($urandom_range(0, 1));

    uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .oversample_tick(oversample_tick), .rx(rx_a),
        .rx_ready(rx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .oversample_tick(oversample_tick), .rx(rx_b),
        .rx_ready(ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int vlow_cnt = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } frame_t;

    frame_t exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected delivery from frame content: odd parity means the total count of ones is odd.
    function automatic frame_t model(input logic [7:0] d, input logic stop, input logic par_en,
                                     input logic par_bit, input logic odd);
        frame_t f;
        f.data = d;
        f.ferr = !stop;
        f.perr = par_en && ((($countones({d, par_bit}) % 2) == 1) != odd);
        return f;
    endfunction

    always @(negedge clk) begin : monitor
        frame_t f;
        if (overrun_a) ovr_cnt++;
        if (!rx_valid_a) vlow_cnt++;
        if (rx_valid_a && rx_ready_a) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got data 0x%0h, expected no frame", rx_data_a);
            end else begin
                f = exp_q.pop_front();
                check("mon_data", 32'(rx_data_a), 32'(f.data));
                check("mon_frame_err", 32'(frame_err_a), 32'(f.ferr));
                check("mon_parity_err", 32'(parity_err_a), 32'(f.perr));
            end
        end
    end

    task automatic set_rx(input bit sel_b, input logic v);
        if (sel_b) rx_b = v;
        else rx_a = v;
    endtask

    // Starts and ends on a negedge; leaves the line at the stop value.
    task automatic send_frame(input bit sel_b, input logic [7:0] d, input bit with_par,
                              input logic par, input logic stop);
        set_rx(sel_b, 1'b0);
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel_b, d[i]);
            repeat (64) @(negedge clk);
        end
        if (with_par) begin
            set_rx(sel_b, par);
            repeat (64) @(negedge clk);
        end
        set_rx(sel_b, stop);
        repeat (64) @(negedge clk);
    endtask

    task automatic accept_a();
        @(posedge clk); #1 man_ready_a = 1'b1;
        @(posedge clk); #1 man_ready_a = 1'b0;
        @(negedge clk);
        check("a_valid_clears", 32'(rx_valid_a), 32'd0);
    endtask

    task automatic accept_b();
        @(posedge clk); #1 ready_b = 1'b1;
        @(posedge clk); #1 ready_b = 1'b0;
        @(negedge clk);
        check("b_valid_clears", 32'(rx_valid_b), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, v0, n;
        logic [7:0] d;
        logic       stop;

        vecs[0] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[7] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", 32'(rx_data_a), 32'd0);
        check("rst_valid", 32'(rx_valid_a), 32'd0);
        check("rst_frame_err", 32'(frame_err_a), 32'd0);
        check("rst_parity_err", 32'(parity_err_a), 32'd0);
        check("rst_overrun", 32'(overrun_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_b_valid", 32'(rx_valid_b), 32'd0);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // 0xA5, held until accepted
        exp_q.push_back(model(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0));
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("a5_valid", 32'(rx_valid_a), 32'd1);
        check("a5_data", 32'(rx_data_a), 32'hA5);
        check("a5_frame_err", 32'(frame_err_a), 32'd0);
        repeat (100) @(negedge clk);
        check("a5_hold_valid", 32'(rx_valid_a), 32'd1);
        check("a5_hold_data", 32'(rx_data_a), 32'hA5);
        accept_a();

        // False start: 4 ticks low
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        check("false_busy_up", 32'(busy_a), 32'd1);
        rx_a = 1'b1;
        repeat (24) @(negedge clk);
        check("false_busy_down", 32'(busy_a), 32'd0);
        repeat (700) @(negedge clk);
        check("false_no_valid", 32'(rx_valid_a), 32'd0);

        // Stop bit 0 then line held low: one frame, busy until line high
        o0 = ovr_cnt;
        exp_q.push_back(model(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (96) @(negedge clk);
        check("brk_busy", 32'(busy_a), 32'd1);
        check("brk_valid", 32'(rx_valid_a), 32'd1);
        check("brk_data", 32'(rx_data_a), 32'h3C);
        check("brk_frame_err", 32'(frame_err_a), 32'd1);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        check("brk_busy_release", 32'(busy_a), 32'd0);
        repeat (700) @(negedge clk);
        check("brk_still_data", 32'(rx_data_a), 32'h3C);
        check("brk_no_overrun", 32'(ovr_cnt - o0), 32'd0);
        accept_a();

        // Back-to-back with rx_ready=0: second frame dropped, one-clk overrun
        o0 = ovr_cnt;
        exp_q.push_back(model(8'h11, 1'b1, 1'b0, 1'b0, 1'b0));
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        check("ovr_data_kept", 32'(rx_data_a), 32'h11);
        check("ovr_valid", 32'(rx_valid_a), 32'd1);
        check("ovr_pulse_clks", 32'(ovr_cnt - o0), 32'd1);
        accept_a();

        // Back-to-back with rx_ready on the stop-sample cycle of the second frame
        exp_q.push_back(model(8'h11, 1'b1, 1'b0, 1'b0, 1'b0));
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        o0 = ovr_cnt;
        v0 = vlow_cnt;
        exp_q.push_back(model(8'h22, 1'b1, 1'b0, 1'b0, 1'b0));
        fork
            send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
            begin
                // 2 clk synchronizer + 1 clk to leave IDLE, then 8+8*16+16 ticks to the stop sample
                repeat (3) @(posedge clk);
                #1;
                n = 0;
                while (n < 152) begin
                    if (oversample_tick) n++;
                    if (n < 152) begin
                        @(posedge clk);
                        #1;
                    end
                end
                man_ready_a = 1'b1;
                @(posedge clk);
                #1 man_ready_a = 1'b0;
            end
        join
        check("same_cycle_valid", 32'(rx_valid_a), 32'd1);
        check("same_cycle_data", 32'(rx_data_a), 32'h22);
        check("same_cycle_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        check("same_cycle_valid_never_low", 32'(vlow_cnt - v0), 32'd0);
        accept_a();

        // Reset during data bit 4 of 0xFF while a frame is pending
        exp_q.push_back(model(8'h99, 1'b1, 1'b0, 1'b0, 1'b0));
        send_frame(1'b0, 8'h99, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (64 * 5 + 32) @(negedge clk);
                reset_n = 1'b0;
                exp_q.delete();
                repeat (2) @(negedge clk);
                check("mid_rst_data", 32'(rx_data_a), 32'd0);
                check("mid_rst_valid", 32'(rx_valid_a), 32'd0);
                check("mid_rst_frame_err", 32'(frame_err_a), 32'd0);
                check("mid_rst_overrun", 32'(overrun_a), 32'd0);
                check("mid_rst_busy", 32'(busy_a), 32'd0);
                repeat (10) @(negedge clk);
                reset_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        check("post_rst_no_valid", 32'(rx_valid_a), 32'd0);
        exp_q.push_back(model(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0));
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        check("post_rst_valid", 32'(rx_valid_a), 32'd1);
        check("post_rst_data", 32'(rx_data_a), 32'h5A);
        accept_a();

        // Odd-parity vector table
        for (int i = 0; i < 8; i++) begin
            send_frame(1'b1, vecs[i].data, 1'b1, vecs[i].par, vecs[i].stop);
            check("par_valid", 32'(rx_valid_b), 32'd1);
            check("par_data", 32'(rx_data_b), 32'(vecs[i].exp_data));
            check("par_frame_err", 32'(frame_err_b), 32'(vecs[i].exp_ferr));
            check("par_parity_err", 32'(parity_err_b), 32'(vecs[i].exp_perr));
            if (!vecs[i].stop) begin
                repeat (100) @(negedge clk);
                rx_b = 1'b1;
                repeat (8) @(negedge clk);
            end
            accept_b();
        end

        // Randomized frames with random downstream backpressure
        o0 = ovr_cnt;
        rand_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            exp_q.push_back(model(d, stop, 1'b0, 1'b0, 1'b0));
            send_frame(1'b0, d, 1'b0, 1'b0, stop);
            if (!stop) begin
                repeat ($urandom_range(1, 100)) @(negedge clk);
                rx_a = 1'b1;
            end
            repeat ($urandom_range(4, 60)) @(negedge clk);
        end
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check("rand_drain", 32'(exp_q.size()), 32'd0);
        check("rand_no_overrun", 32'(ovr_cnt - o0), 32'd0);
        rand_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
